// File: rtl/rv64g_reg_lock_tracker.sv
// ---------------------------------------------------------------------------
// rv64g_reg_lock_tracker
//
// Register-lock scoreboard at the far end of the launch path. Each launched
// instruction that writes a destination register bumps a small per-register
// pending-write counter. Each writeback port strobe decrements it again. The
// launcher uses the resulting lock vector for its hazard checks. Because a
// counter is kept per register, several in-flight writes to one register are
// tracked correctly.
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset
//   clear_i         synchronous flush (pipeline kill); same effect as reset
//   launch_valid_i  launched instruction valid
//   launch_ready_o  tracker can accept the launch (never depends on valid)
//   launch_wr_en_i  launched instruction writes rd
//   launch_rd_i     destination register of the launched instruction
//   wb_valid_i      per-port writeback/unlock strobe
//   wb_rd_i         per-port register being unlocked
//   locks_o         bit r set while register r has pending writes
//   outstanding_o   total pending writes across all registers
//   wb_err_o        sticky: unlock seen for a register with nothing pending
// ---------------------------------------------------------------------------
module rv64g_reg_lock_tracker #(
  parameter int NR  = 64,
  parameter int NWB = 2,
  parameter int CW  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           launch_valid_i,
  output logic                           launch_ready_o,
  input  logic                           launch_wr_en_i,
  input  logic [$clog2(NR)-1:0]          launch_rd_i,
  input  logic [NWB-1:0]                 wb_valid_i,
  input  logic [NWB-1:0][$clog2(NR)-1:0] wb_rd_i,
  output logic [NR-1:0]                  locks_o,
  output logic [$clog2(NR)+CW-1:0]       outstanding_o,
  output logic                           wb_err_o
);

  localparam int AW = $clog2(NR);
  localparam int TW = AW + CW;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [NR-1:0][CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]         tot_q, tot_d;
  logic                  err_q, err_d;

  logic                  at_max;
  logic                  inc_en;
  logic [TW-1:0]         dec_req;
  logic [TW-1:0]         cur;
  logic [TW-1:0]         inc;

  // Ready only looks at the current counter value, so a writeback arriving in
  // the same cycle never opens the gate: there is no wb -> ready path.
  always_comb begin
    at_max = launch_wr_en_i && (launch_rd_i != '0) && (cnt_q[launch_rd_i] == CNT_MAX);
    launch_ready_o = !(rst_i || clear_i) && !at_max;
    inc_en = launch_valid_i && launch_ready_o && launch_wr_en_i && (launch_rd_i != '0);
  end

  // Next-state for every counter: launch increment and the (clamped)
  // writeback decrements are applied together. Decrements are clamped
  // against the old count only, so an over-unlock floors at zero and raises
  // the sticky error even when a launch to the same register is also firing.
  // The total is moved by exactly the same net delta as the counters.
  always_comb begin
    cnt_d   = cnt_q;
    tot_d   = tot_q;
    err_d   = err_q;
    dec_req = '0;
    cur     = '0;
    inc     = '0;
    cnt_d[0] = '0;
    for (int r = 1; r < NR; r++) begin
      dec_req = '0;
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid_i[k] && (wb_rd_i[k] == AW'(r))) begin
          dec_req = dec_req + TW'(1);
        end
      end
      cur = TW'(cnt_q[r]);
      if (dec_req > cur) begin
        err_d   = 1'b1;
        dec_req = cur;
      end
      inc = (inc_en && (launch_rd_i == AW'(r))) ? TW'(1) : '0;
      cnt_d[r] = CW'(cur + inc - dec_req);
      tot_d    = tot_d + inc - dec_req;
    end
    // A flush discards everything presented in this cycle.
    if (clear_i) begin
      cnt_d = '0;
      tot_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    locks_o = '0;
    for (int r = 0; r < NR; r++) begin
      locks_o[r] = (cnt_q[r] != '0);
    end
  end

  assign outstanding_o = tot_q;
  assign wb_err_o      = err_q;

endmodule

// File: tb/tb_rv64g_reg_lock_tracker.sv
// ---------------------------------------------------------------------------
// tb_rv64g_reg_lock_tracker
//
// Drives the lock tracker through reset, single lock/unlock, saturation,
// simultaneous launch/writeback, x0 handling, over-unlock errors, flush and
// a stretch of random traffic. A behavioural model predicts the state after
// every edge; predictions are queued when stimulus is applied and popped
// once the DUT has updated.
// ---------------------------------------------------------------------------
module tb_rv64g_reg_lock_tracker;

  typedef struct {
    logic [63:0] locks;
    logic [7:0]  tot;
    logic        err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr = 1'b0;
  logic            lv = 1'b0;
  logic            wr = 1'b0;
  logic [5:0]      rd = '0;
  logic [1:0]      wbv = '0;
  logic [1:0][5:0] wbrd = '0;
  logic            ready;
  logic [63:0]     locks;
  logic [7:0]      outstanding;
  logic            wb_err;

  exp_t sbq[$];
  int   m_cnt[64];
  logic m_err = 1'b0;
  int   checks = 0;
  int   passed = 0;

  rv64g_reg_lock_tracker #(.NR(64), .NWB(2), .CW(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clr),
    .launch_valid_i (lv),
    .launch_ready_o (ready),
    .launch_wr_en_i (wr),
    .launch_rd_i    (rd),
    .wb_valid_i     (wbv),
    .wb_rd_i        (wbrd),
    .locks_o        (locks),
    .outstanding_o  (outstanding),
    .wb_err_o       (wb_err)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic model_ready();
    return !(rst || clr) && !(wr && (rd != 6'd0) && (m_cnt[rd] == 3));
  endfunction

  // Advance the model by one edge using the currently driven inputs and
  // queue the state the DUT should show afterwards.
  task automatic model_push();
    exp_t e;
    int   need[64];
    logic fire_inc;
    if (rst || clr) begin
      for (int r = 0; r < 64; r++) m_cnt[r] = 0;
      m_err = 1'b0;
    end else begin
      fire_inc = lv && model_ready() && wr && (rd != 6'd0);
      for (int r = 0; r < 64; r++) need[r] = 0;
      for (int k = 0; k < 2; k++) begin
        if (wbv[k] && (wbrd[k] != 6'd0)) need[wbrd[k]] = need[wbrd[k]] + 1;
      end
      for (int r = 1; r < 64; r++) begin
        if (need[r] > m_cnt[r]) begin
          m_err    = 1'b1;
          m_cnt[r] = 0;
        end else begin
          m_cnt[r] = m_cnt[r] - need[r];
        end
      end
      if (fire_inc) m_cnt[rd] = m_cnt[rd] + 1;
    end
    e.locks = '0;
    e.tot   = '0;
    for (int r = 0; r < 64; r++) begin
      if (m_cnt[r] != 0) e.locks[r] = 1'b1;
      e.tot = e.tot + 8'(m_cnt[r]);
    end
    e.err = m_err;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic v, input logic w, input logic [5:0] d,
                       input logic [1:0] bv, input logic [5:0] b0, input logic [5:0] b1);
    lv = v;
    wr = w;
    rd = d;
    wbv = bv;
    wbrd[0] = b0;
    wbrd[1] = b1;
    #1;
  endtask

  task automatic step();
    model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 6'd5, 2'b00, 6'd0, 6'd0);
      checks++;
      if (ready !== 1'b0) $display("[TB] FAIL reset_ready got %b expected 0", ready);
      else passed++;
      step();
      e = sbq.pop_front();
      checks++;
      if (locks !== e.locks) $display("[TB] FAIL reset_locks got %h expected %h", locks, e.locks);
      else passed++;
      checks++;
      if (outstanding !== e.tot) $display("[TB] FAIL reset_tot got %0d expected %0d", outstanding, e.tot);
      else passed++;
      checks++;
      if (wb_err !== e.err) $display("[TB] FAIL reset_err got %b expected %b", wb_err, e.err);
      else passed++;
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0);
    checks++;
    if (ready !== 1'b1) $display("[TB] FAIL idle_ready got %b expected 1", ready);
    else passed++;
  endtask

  task automatic test_single_lock();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      case (i)
        0: drive(1'b1, 1'b1, 6'd5, 2'b00, 6'd0, 6'd0);
        default: drive(1'b0, 1'b0, 6'd0, 2'b01, 6'd5, 6'd0);
      endcase
      step();
      e = sbq.pop_front();
      checks++;
      if (locks !== e.locks) $display("[TB] FAIL single_locks step %0d got %h expected %h", i, locks, e.locks);
      else passed++;
      checks++;
      if (outstanding !== e.tot) $display("[TB] FAIL single_tot step %0d got %0d expected %0d", i, outstanding, e.tot);
      else passed++;
      checks++;
      if (wb_err !== e.err) $display("[TB] FAIL single_err step %0d got %b expected %b", i, wb_err, e.err);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0, 1, 2: drive(1'b1, 1'b1, 6'd7, 2'b00, 6'd0, 6'd0);
        3: begin
          drive(1'b0, 1'b1, 6'd8, 2'b00, 6'd0, 6'd0);
          checks++;
          if (ready !== 1'b1) $display("[TB] FAIL sat_ready_rd8 got %b expected 1", ready);
          else passed++;
          drive(1'b1, 1'b1, 6'd7, 2'b00, 6'd0, 6'd0);
          checks++;
          if (ready !== 1'b0) $display("[TB] FAIL sat_ready_rd7 got %b expected 0", ready);
          else passed++;
        end
        4: begin
          // Blocked launch plus a writeback: still not ready this cycle.
          drive(1'b1, 1'b1, 6'd7, 2'b01, 6'd7, 6'd0);
          checks++;
          if (ready !== 1'b0) $display("[TB] FAIL sat_ready_with_wb got %b expected 0", ready);
          else passed++;
        end
        default: begin
          drive(1'b0, 1'b1, 6'd7, 2'b00, 6'd0, 6'd0);
          checks++;
          if (ready !== 1'b1) $display("[TB] FAIL sat_ready_back got %b expected 1", ready);
          else passed++;
          drive(1'b0, 1'b0, 6'd0, 2'b11, 6'd7, 6'd7);
        end
      endcase
      step();
      e = sbq.pop_front();
      checks++;
      if (locks !== e.locks) $display("[TB] FAIL sat_locks step %0d got %h expected %h", i, locks, e.locks);
      else passed++;
      checks++;
      if (outstanding !== e.tot) $display("[TB] FAIL sat_tot step %0d got %0d expected %0d", i, outstanding, e.tot);
      else passed++;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0, 2: drive(1'b1, 1'b1, 6'd9, 2'b00, 6'd0, 6'd0);
        1: drive(1'b1, 1'b1, 6'd9, 2'b01, 6'd9, 6'd0);
        default: drive(1'b0, 1'b0, 6'd0, 2'b11, 6'd9, 6'd9);
      endcase
      step();
      e = sbq.pop_front();
      checks++;
      if (locks !== e.locks) $display("[TB] FAIL simul_locks step %0d got %h expected %h", i, locks, e.locks);
      else passed++;
      checks++;
      if (outstanding !== e.tot) $display("[TB] FAIL simul_tot step %0d got %0d expected %0d", i, outstanding, e.tot);
      else passed++;
      checks++;
      if (wb_err !== e.err) $display("[TB] FAIL simul_err step %0d got %b expected %b", i, wb_err, e.err);
      else passed++;
    end
  endtask

  task automatic test_x0_and_err();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: drive(1'b1, 1'b1, 6'd0, 2'b00, 6'd0, 6'd0);
        1: drive(1'b0, 1'b0, 6'd0, 2'b11, 6'd0, 6'd0);
        2: drive(1'b1, 1'b1, 6'd13, 2'b00, 6'd0, 6'd0);
        3: drive(1'b0, 1'b0, 6'd0, 2'b11, 6'd13, 6'd13);
        6: begin
          clr = 1'b1;
          drive(1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0);
        end
        default: drive(1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0);
      endcase
      step();
      clr = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (locks !== e.locks) $display("[TB] FAIL x0err_locks step %0d got %h expected %h", i, locks, e.locks);
      else passed++;
      checks++;
      if (outstanding !== e.tot) $display("[TB] FAIL x0err_tot step %0d got %0d expected %0d", i, outstanding, e.tot);
      else passed++;
      checks++;
      if (wb_err !== e.err) $display("[TB] FAIL x0err_err step %0d got %b expected %b", i, wb_err, e.err);
      else passed++;
    end
  endtask

  task automatic test_flush();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1'b1, 1'b1, 6'd3, 2'b00, 6'd0, 6'd0);
        1: drive(1'b1, 1'b1, 6'd40, 2'b00, 6'd0, 6'd0);
        2: drive(1'b0, 1'b0, 6'd0, 2'b10, 6'd0, 6'd12);
        3: drive(1'b0, 1'b0, 6'd0, 2'b00, 6'd0, 6'd0);
        default: begin
          clr = 1'b1;
          drive(1'b1, 1'b1, 6'd4, 2'b01, 6'd3, 6'd0);
          checks++;
          if (ready !== 1'b0) $display("[TB] FAIL flush_ready got %b expected 0", ready);
          else passed++;
        end
      endcase
      step();
      clr = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (locks !== e.locks) $display("[TB] FAIL flush_locks step %0d got %h expected %h", i, locks, e.locks);
      else passed++;
      checks++;
      if (outstanding !== e.tot) $display("[TB] FAIL flush_tot step %0d got %0d expected %0d", i, outstanding, e.tot);
      else passed++;
      checks++;
      if (wb_err !== e.err) $display("[TB] FAIL flush_err step %0d got %b expected %b", i, wb_err, e.err);
      else passed++;
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic exp_ready;
    for (int i = 0; i < 300; i++) begin
      clr = ($urandom_range(0, 40) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 6'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
      exp_ready = model_ready();
      checks++;
      if (ready !== exp_ready) $display("[TB] FAIL rand_ready iter %0d got %b expected %b", i, ready, exp_ready);
      else passed++;
      step();
      clr = 1'b0;
      e = sbq.pop_front();
      checks++;
      if (locks !== e.locks) $display("[TB] FAIL rand_locks iter %0d got %h expected %h", i, locks, e.locks);
      else passed++;
      checks++;
      if (outstanding !== e.tot) $display("[TB] FAIL rand_tot iter %0d got %0d expected %0d", i, outstanding, e.tot);
      else passed++;
      checks++;
      if (wb_err !== e.err) $display("[TB] FAIL rand_err iter %0d got %b expected %b", i, wb_err, e.err);
      else passed++;
    end
  endtask

  initial begin
    for (int r = 0; r < 64; r++) m_cnt[r] = 0;
    #1;
    test_reset();
    test_single_lock();
    test_saturation();
    test_simultaneous();
    test_x0_and_err();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rv64g_reg_lock_tracker.md
Name: rv64g_reg_lock_tracker

Overview:
- Register-lock scoreboard at the far end of the launch path: it tracks destination registers of launched instructions and releases them on writeback.
- Produces the per-register lock vector consumed by the instruction launcher's hazard checks.
- Sits between the launcher output, the execution units' writeback ports and the launcher's lock input.
- Keeps a small pending-write counter per register, so several in-flight writes to one register are tracked correctly.

Parameters:
- NR, rv64g_pkg::NUM_REGS (64), number of architectural registers (integer + FP); index 0 is x0.
- NWB, 2, number of independent writeback/unlock ports.
- CW, 2, width of each per-register pending-write counter; MAX = 2^CW-1.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous flush (pipeline kill), active-high.
- launch_valid_i  in  1  launched instruction valid.
- launch_ready_o  out  1  tracker can accept the launch.
- launch_wr_en_i  in  1  launched instruction writes rd.
- launch_rd_i  in  $clog2(NR)  destination register of launched instruction.
- wb_valid_i  in  NWB  per-port writeback/unlock strobe.
- wb_rd_i  in  NWB x $clog2(NR)  per-port register being unlocked.
- locks_o  out  NR  bit r = 1 while register r has pending writes.
- outstanding_o  out  $clog2(NR)+CW  total pending writes across all registers.
- wb_err_o  out  1  sticky: unlock received for a register with zero pending writes.

Behaviour:
- State: cnt[r] (CW bits) for r = 1..NR-1; cnt[0] is constant 0. Sticky err flag. Total count register tot.
- Reset (rst_i = 1 at an edge): all cnt = 0, tot = 0, err = 0. Outputs after reset: locks_o = 0, outstanding_o = 0, wb_err_o = 0, launch_ready_o = 1 unless rst_i or clear_i is currently high.
- locks_o[r] = (cnt[r] != 0), driven from registers. A lock is visible the cycle after launch and drops the cycle after writeback.
- launch_ready_o:
  - 0 while rst_i or clear_i is high.
  - Otherwise 0 only if launch_wr_en_i = 1, launch_rd_i != 0 and cnt[launch_rd_i] == MAX.
  - Otherwise 1. It may depend combinationally on launch_rd_i and launch_wr_en_i, never on launch_valid_i.
- Launch fire = launch_valid_i & launch_ready_o.
  - Fire increments cnt[launch_rd_i] only if launch_wr_en_i = 1 and launch_rd_i != 0.
  - A fire without a write, or with rd = 0, changes no state.
- Writeback, for each port k with wb_valid_i[k] = 1:
  - wb_rd_i[k] = 0: ignored.
  - Otherwise decrement cnt[wb_rd_i[k]].
  - Several ports naming the same register in one cycle each decrement it.
  - If the requested decrements exceed the current cnt (launch increment excluded), the counter floors at 0 and err is set.
- Same-cycle launch and writeback on one register: next cnt = cnt + inc - dec, evaluated together. At MAX, ready stays 0 even if a writeback is present, so there is no combinational path from wb to ready.
- tot tracks the sum of all cnt and is updated with the same net delta. outstanding_o = tot.
- clear_i = 1: at the edge, all cnt, tot and err go to 0. Launches and writebacks in that cycle are discarded. Reset has priority over clear_i; their effects are identical.
- wb_err_o holds at 1 until reset or clear.
- No other latency. The block has no FSM beyond the counters; all state changes take 1 cycle.

Test Plan:
- Reset then idle: rst_i high 2 cycles, then low -> locks_o = 0, outstanding_o = 0, wb_err_o = 0, launch_ready_o = 1.
- Single lock/unlock: launch rd = 5 with wr_en -> locks_o[5] = 1 next cycle and outstanding_o = 1. Then wb_valid_i[0] with rd 5 -> locks_o[5] = 0 next cycle and outstanding_o = 0.
- Saturation:
  - Launch rd = 7 three times (CW = 2): cnt = 3, then launch_ready_o = 0 for rd 7 but 1 for rd 8.
  - One writeback to 7: ready for rd 7 returns the following cycle, locks_o[7] stays 1.
- Simultaneous events:
  - cnt[9] = 1; same cycle launch rd 9 plus wb port 0 rd 9 -> cnt[9] stays 1 and outstanding_o unchanged.
  - Both wb ports on rd 9 with cnt = 2 -> lock clears in one cycle.
- x0 and errors:
  - Launch rd 0 -> no lock, outstanding_o unchanged.
  - wb to rd 12 with cnt 0 -> wb_err_o = 1 next cycle and stays 1 until clear_i.
- Flush mid-operation: locks on rd 3 and 40, pulse clear_i with a concurrent launch to rd 4 -> next cycle locks_o = 0, outstanding_o = 0, wb_err_o = 0, rd 4 not locked, launch_ready_o = 0 during the clear cycle.
